// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder.
// One full-adder cell and a carry flip-flop process one bit pair per clock,
// LSB first. The sum is assembled in a right-shifting register. S, C_out and V
// are presented together with a one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             V
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_sh_q;
  logic             cy_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] s_q;
  logic             c_out_q;
  logic             v_q;

  logic             sum_bit_d;
  logic             cout_d;
  logic [WIDTH-1:0] sum_sh_d;

  // The single full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    full_add = {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

  // Current bit's sum/carry and the sum register after shifting the new bit in at the MSB.
  always_comb begin
    sum_bit_d = 1'b0;
    cout_d    = 1'b0;
    {cout_d, sum_bit_d} = full_add(a_sh_q[0], b_sh_q[0], cy_q);
    sum_sh_d  = {sum_bit_d, sum_sh_q[WIDTH-1:1]};
  end

  // Control FSM with datapath shift registers and registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      cy_q     <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      s_q      <= '0;
      c_out_q  <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q  <= A;
            b_sh_q  <= B;
            cy_q    <= C_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          sum_sh_q <= sum_sh_d;
          cy_q     <= cout_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            // Overflow uses the carry into the MSB, i.e. cy before this update.
            s_q     <= sum_sh_d;
            c_out_q <= cout_d;
            v_q     <= cy_q ^ cout_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign S     = s_q;
  assign C_out = c_out_q;
  assign V     = v_q;

endmodule
